// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared pipeline encodings (Tuse/Tnew), multiply/divide
//                latency defaults, MD timer state type and hazard helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

   // Tuse: cycles until a source operand is consumed, counted from D
   localparam logic [1:0] TUSE_D    = 2'd0;
   localparam logic [1:0] TUSE_E    = 2'd1;
   localparam logic [1:0] TUSE_M    = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   // Tnew: cycles until a produced result can be forwarded
   localparam logic [1:0] TNEW_READY = 2'd0;
   localparam logic [1:0] TNEW_ONE   = 2'd1;
   localparam logic [1:0] TNEW_TWO   = 2'd2;

   // Multiply/divide unit occupancy in cycles
   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;
   localparam int MD_CNT_W    = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   // A source operand must wait when a younger-stage producer writes the
   // same (non-zero) register and its result arrives later than it is needed.
   function automatic logic reg_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] waddr_e,
      input logic [1:0] tnew_e,
      input logic [4:0] waddr_m,
      input logic [1:0] tnew_m
   );
      logic w_e;
      logic w_m;
      w_e = (src == waddr_e) && (tnew_e > tuse);
      w_m = (src == waddr_m) && (tnew_m > tuse);
      return (src != 5'd0) && (tuse != TUSE_NONE) && (w_e || w_m);
   endfunction

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : Tracks occupancy of the multiply/divide unit. A start in
//                IDLE loads the op latency; the unit reports busy until the
//                down-counter expires. Starts while busy are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_timer
   import mips_pipe_pkg::*;
#(
   parameter int MULT_CYCLES = mips_pipe_pkg::MULT_CYCLES,
   parameter int DIV_CYCLES  = mips_pipe_pkg::DIV_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_start,
   input  logic i_op,
   output logic o_busy
);

   localparam logic [MD_CNT_W-1:0] C_MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] C_DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

   md_state_t             r_state;
   logic [MD_CNT_W-1:0]   r_cnt;
   logic                  r_busy;

   // Timer FSM: load on start from IDLE, count down while BUSY, busy is registered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= BUSY;
                  r_cnt   <= i_op ? C_DIV_LOAD : C_MULT_LOAD;
                  r_busy  <= 1'b1;
               end
            end
            BUSY: begin
               // A count of one is the last busy cycle; <= guards a zero load
               if (r_cnt <= MD_CNT_W'(1)) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt - MD_CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;

endmodule : md_busy_timer
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard unit. Detects Tuse/Tnew register hazards on
//                rs/rt and multiply/divide structural hazards, produces the
//                stall / ID-EX flush and counts stall cycles (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MULT_CYCLES = mips_pipe_pkg::MULT_CYCLES,
   parameter int DIV_CYCLES  = mips_pipe_pkg::DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  tuse_rs_D,
   input  logic [1:0]  tuse_rt_D,
   input  logic [4:0]  waddr_E,
   input  logic [1:0]  tnew_E,
   input  logic [4:0]  waddr_M,
   input  logic [1:0]  tnew_M,
   input  logic        md_start_E,
   input  logic        md_op_E,
   input  logic        md_use_D,
   output logic        stall,
   output logic        flush_E,
   output logic        md_busy,
   output logic [15:0] stall_cnt
);

   logic        w_rs_hz;
   logic        w_rt_hz;
   logic        w_md_hz;
   logic        w_md_busy;
   logic        w_stall;
   logic [15:0] r_stall_cnt;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_timer (
      .clk     (clk),
      .reset   (reset),
      .i_start (md_start_E),
      .i_op    (md_op_E),
      .o_busy  (w_md_busy)
   );

   // Hazard detection is purely combinational so the stall takes effect this cycle
   always_comb begin
      w_rs_hz = reg_hazard(rs_D, tuse_rs_D, waddr_E, tnew_E, waddr_M, tnew_M);
      w_rt_hz = reg_hazard(rt_D, tuse_rt_D, waddr_E, tnew_E, waddr_M, tnew_M);
      w_md_hz = md_use_D && (w_md_busy || md_start_E);
      w_stall = !reset && (w_rs_hz || w_rt_hz || w_md_hz);
   end

   // Stall-cycle counter, saturating at all ones
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall     = w_stall;
   assign flush_E   = w_stall;
   assign md_busy   = w_md_busy;
   assign stall_cnt = r_stall_cnt;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl with a cycle-indexed
//                reference model (busy window end time, integer counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_D, rt_D, waddr_E, waddr_M;
   logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
   logic        md_start_E, md_op_E, md_use_D;
   logic        stall, flush_E, md_busy;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: the unit is busy while cyc < busy_end
   longint cyc      = 0;
   longint busy_end = 0;
   int     m_cnt    = 0;

   hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk        (clk),
      .reset      (reset),
      .rs_D       (rs_D),
      .rt_D       (rt_D),
      .tuse_rs_D  (tuse_rs_D),
      .tuse_rt_D  (tuse_rt_D),
      .waddr_E    (waddr_E),
      .tnew_E     (tnew_E),
      .waddr_M    (waddr_M),
      .tnew_M     (tnew_M),
      .md_start_E (md_start_E),
      .md_op_E    (md_op_E),
      .md_use_D   (md_use_D),
      .stall      (stall),
      .flush_E    (flush_E),
      .md_busy    (md_busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit m_busy();
      return cyc < busy_end;
   endfunction

   function automatic bit m_src_hz(input logic [4:0] src, input logic [1:0] tuse);
      int need, ready_e, ready_m;
      if (src == 5'd0 || tuse == 2'd3) return 1'b0;
      need    = int'(tuse);
      ready_e = int'(tnew_E);
      ready_m = int'(tnew_M);
      return (src == waddr_E && ready_e > need) || (src == waddr_M && ready_m > need);
   endfunction

   function automatic bit m_stall();
      if (reset) return 1'b0;
      return m_src_hz(rs_D, tuse_rs_D) || m_src_hz(rt_D, tuse_rt_D)
             || (md_use_D && (m_busy() || md_start_E));
   endfunction

   // Advance one clock edge and the model alongside it
   task automatic tick();
      bit s, b;
      s = m_stall();
      b = m_busy();
      @(posedge clk);
      if (reset) begin
         busy_end = 0;
         m_cnt    = 0;
      end else begin
         if (s) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (!b && md_start_E) busy_end = cyc + 1 + (md_op_E ? DIV_N : MULT_N);
      end
      cyc = cyc + 1;
      #2;
   endtask

   task automatic set_idle();
      rs_D = 0; rt_D = 0; waddr_E = 0; waddr_M = 0;
      tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = 0; tnew_M = 0;
      md_start_E = 0; md_op_E = 0; md_use_D = 0;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1'b1;
      rs_D = 8; waddr_E = 8; tnew_E = 2; tuse_rs_D = 1; md_use_D = 1; md_start_E = 1;
      #1;
      checks++;
      if (stall !== 1'b0 || flush_E !== 1'b0) begin
         errors++; $display("FAIL reset_stall: stall=%b flush=%b required 0/0", stall, flush_E);
      end
      tick(); tick();
      checks++;
      if (md_busy !== 1'b0 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_state: busy=%b cnt=%0d required 0/0", md_busy, stall_cnt);
      end
      set_idle();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_load_use();
      do_reset();
      rs_D = 8; waddr_E = 8; tnew_E = 2; tuse_rs_D = 1;
      #1;
      checks++;
      if (stall !== 1'b1 || flush_E !== 1'b1) begin
         errors++; $display("FAIL load_use_stall: stall=%b flush=%b required 1/1", stall, flush_E);
      end
      tick();
      waddr_E = 0; tnew_E = 0; waddr_M = 8; tnew_M = 1;
      #1;
      checks++;
      if (stall !== 1'b0 || flush_E !== 1'b0) begin
         errors++; $display("FAIL load_use_release: stall=%b flush=%b required 0/0", stall, flush_E);
      end
      checks++;
      if (stall_cnt !== 16'd1) begin
         errors++; $display("FAIL load_use_cnt: got %0d required 1", stall_cnt);
      end
      tick();
   endtask

   task automatic test_reg_zero();
      do_reset();
      rs_D = 0; waddr_E = 0; tnew_E = 2; tuse_rs_D = 0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL reg_zero: stall=%b required 0", stall);
      end
      tick();
   endtask

   task automatic test_mult();
      do_reset();
      md_start_E = 1; md_op_E = 0; md_use_D = 1;
      #1;
      checks++;
      if (stall !== 1'b1 || md_busy !== 1'b0) begin
         errors++; $display("FAIL mult_start: stall=%b busy=%b required 1/0", stall, md_busy);
      end
      tick();
      md_start_E = 0;
      for (int i = 0; i < MULT_N; i++) begin
         #1;
         checks++;
         if (stall !== 1'b1 || md_busy !== 1'b1) begin
            errors++; $display("FAIL mult_busy[%0d]: stall=%b busy=%b required 1/1", i, stall, md_busy);
         end
         tick();
      end
      #1;
      checks++;
      if (stall !== 1'b0 || md_busy !== 1'b0 || stall_cnt !== 16'd6) begin
         errors++; $display("FAIL mult_end: stall=%b busy=%b cnt=%0d required 0/0/6", stall, md_busy, stall_cnt);
      end
      set_idle();
   endtask

   task automatic test_div_reset();
      do_reset();
      md_start_E = 1; md_op_E = 1; md_use_D = 1;
      tick();
      md_start_E = 0;
      for (int i = 0; i < 3; i++) tick();
      #1;
      checks++;
      if (md_busy !== 1'b1) begin
         errors++; $display("FAIL div_busy4: busy=%b required 1", md_busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL div_reset_stall: stall=%b required 0", stall);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (md_busy !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL div_after_reset: busy=%b stall=%b cnt=%0d required 0/0/0", md_busy, stall, stall_cnt);
      end
      for (int i = 0; i < DIV_N; i++) begin
         tick();
         checks++;
         if (md_busy !== 1'b0) begin
            errors++; $display("FAIL div_residual[%0d]: busy=%b required 0", i, md_busy);
         end
      end
      set_idle();
   endtask

   task automatic test_ignored_start();
      int busy_seen;
      do_reset();
      md_start_E = 1; md_op_E = 0;
      tick();
      md_start_E = 0;
      tick(); tick();
      // third busy cycle: count is 3 here
      md_start_E = 1; md_op_E = 1;
      busy_seen = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (md_busy === 1'b1) busy_seen++;
         tick();
         md_start_E = 0;
      end
      checks++;
      if (busy_seen != 3) begin
         errors++; $display("FAIL ignored_start: busy cycles after restart %0d required 3", busy_seen);
      end
      set_idle();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 99) < 2);
         rs_D       = 5'($urandom_range(0, 3));
         rt_D       = 5'($urandom_range(0, 3));
         waddr_E    = 5'($urandom_range(0, 3));
         waddr_M    = 5'($urandom_range(0, 3));
         tuse_rs_D  = 2'($urandom_range(0, 3));
         tuse_rt_D  = 2'($urandom_range(0, 3));
         tnew_E     = 2'($urandom_range(0, 3));
         tnew_M     = 2'($urandom_range(0, 3));
         md_start_E = ($urandom_range(0, 9) == 0);
         md_op_E    = 1'($urandom_range(0, 1));
         md_use_D   = ($urandom_range(0, 3) == 0);
         #1;
         checks++;
         if (stall !== m_stall() || flush_E !== m_stall()) begin
            errors++; $display("FAIL rand_stall@%0d: stall=%b flush=%b required %b", n, stall, flush_E, m_stall());
         end
         checks++;
         if (md_busy !== m_busy() || stall_cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL rand_state@%0d: busy=%b cnt=%0d required %b/%0d", n, md_busy, stall_cnt, m_busy(), m_cnt);
         end
         tick();
      end
      reset = 1'b0;
      set_idle();
   endtask

   task automatic test_saturation();
      do_reset();
      rt_D = 9; waddr_M = 9; tnew_M = 2; tuse_rt_D = 0;
      for (int i = 0; i < 65540; i++) tick();
      #1;
      checks++;
      if (stall_cnt !== 16'hFFFF || m_cnt != 65535) begin
         errors++; $display("FAIL saturation: cnt=%0h required ffff", stall_cnt);
      end
      tick();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL saturation_hold: cnt=%0h required ffff", stall_cnt);
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      test_reset();
      test_load_use();
      test_reg_zero();
      test_mult();
      test_div_reset();
      test_ignored_start();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hazard_ctrl
`default_nettype wire
